// File: rtl/imm_ext_pkg.sv
// Shared constants for the immediate-extension arbiter: extension modes and
// output-buffer state encoding.
package imm_ext_pkg;

  localparam logic [1:0] MODE_SIGN   = 2'b00;
  localparam logic [1:0] MODE_ZERO   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extender: widens an IN_W immediate to
// 2*IN_W bits according to the selected mode.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W = 16
) (
  input  logic [IN_W-1:0]   in_i,
  input  logic [1:0]        mode_i,
  output logic [2*IN_W-1:0] out_o
);

  always_comb begin
    out_o = {{IN_W{in_i[IN_W-1]}}, in_i};
    case (mode_i)
      MODE_SIGN:   out_o = {{IN_W{in_i[IN_W-1]}}, in_i};
      MODE_ZERO:   out_o = {{IN_W{1'b0}}, in_i};
      MODE_UPPER:  out_o = {in_i, {IN_W{1'b0}}};
      // Branch offset: sign-extend then scale by 4; the top two sign bits fall off.
      MODE_BRANCH: out_o = {{(IN_W-2){in_i[IN_W-1]}}, in_i, 2'b00};
      default:     out_o = {{IN_W{in_i[IN_W-1]}}, in_i};
    endcase
  end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one immediate extender between decode (port 0)
// and the matrix-address generator (port 1), with a single-entry output buffer.
module imm_ext_arbiter
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Req0Valid,
  input  logic             Req1Valid,
  output logic             Req0Ready,
  output logic             Req1Ready,
  input  logic [IN_W-1:0]  Req0In,
  input  logic [IN_W-1:0]  Req1In,
  input  logic [1:0]       Req0Mode,
  input  logic [1:0]       Req1Mode,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [OUT_W-1:0] OutData,
  output logic             OutSrc,
  output logic [CNT_W-1:0] AcceptCnt,
  output buf_state_e       DbgState
);

  // Handshake: a requester's item transfers on a cycle where ReqNValid and
  // ReqNReady are both high; the result transfers where OutValid and OutReady
  // are both high. ReqNReady never depends on ReqNReady of the other port.

  buf_state_e       state_q;
  logic [OUT_W-1:0] data_q;
  logic             src_q;
  logic             last_grant_q;
  logic [CNT_W-1:0] cnt_q;

  logic             load_d;
  logic             grant_d;
  logic             accept_d;
  logic [IN_W-1:0]  mux_in_d;
  logic [1:0]       mux_mode_d;
  logic [OUT_W-1:0] ext_d;
  logic [CNT_W-1:0] cnt_inc_d;

  assign load_d = (state_q == ST_EMPTY) || OutReady;

  // Contested cycles go to the port that did not win last time.
  always_comb begin
    grant_d = 1'b0;
    if (Req0Valid && Req1Valid) grant_d = ~last_grant_q;
    else if (Req1Valid)         grant_d = 1'b1;
  end

  assign accept_d   = load_d && (Req0Valid || Req1Valid);
  assign Req0Ready  = accept_d && (grant_d == 1'b0);
  assign Req1Ready  = accept_d && (grant_d == 1'b1);
  assign mux_in_d   = grant_d ? Req1In : Req0In;
  assign mux_mode_d = grant_d ? Req1Mode : Req0Mode;
  assign cnt_inc_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  imm_ext_core #(.IN_W(IN_W)) u_core (
    .in_i   (mux_in_d),
    .mode_i (mux_mode_d),
    .out_o  (ext_d)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_EMPTY;
      data_q       <= '0;
      src_q        <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      if (accept_d) begin
        state_q      <= ST_FULL;
        data_q       <= ext_d;
        src_q        <= grant_d;
        last_grant_q <= grant_d;
        if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_inc_d;
      end else if (OutReady) begin
        state_q <= ST_EMPTY;
      end
    end
  end

  assign OutValid  = (state_q == ST_FULL);
  assign OutData   = data_q;
  assign OutSrc    = src_q;
  assign AcceptCnt = cnt_q;
  assign DbgState  = state_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed self-checking bench for imm_ext_arbiter; a second instance with a
// 4-bit counter exercises counter saturation.
module tb_imm_ext_arbiter;
  import imm_ext_pkg::*;

  logic        Clk;
  logic        Reset_n;
  logic        Req0Valid, Req1Valid;
  logic        Req0Ready, Req1Ready;
  logic [15:0] Req0In, Req1In;
  logic [1:0]  Req0Mode, Req1Mode;
  logic        OutValid, OutReady, OutSrc;
  logic [31:0] OutData;
  logic [15:0] AcceptCnt;
  buf_state_e  DbgState;

  logic        s_req0_valid, s_req0_ready, s_req1_ready;
  logic        s_out_valid, s_out_src;
  logic [31:0] s_out_data;
  logic [3:0]  s_cnt;
  buf_state_e  s_state;

  int checks = 0;
  int errors = 0;

  imm_ext_arbiter #(.IN_W(16), .OUT_W(32), .CNT_W(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Req0Valid(Req0Valid), .Req1Valid(Req1Valid),
    .Req0Ready(Req0Ready), .Req1Ready(Req1Ready),
    .Req0In(Req0In), .Req1In(Req1In),
    .Req0Mode(Req0Mode), .Req1Mode(Req1Mode),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutData(OutData), .OutSrc(OutSrc),
    .AcceptCnt(AcceptCnt), .DbgState(DbgState)
  );

  imm_ext_arbiter #(.IN_W(16), .OUT_W(32), .CNT_W(4)) u_sat (
    .Clk(Clk), .Reset_n(Reset_n),
    .Req0Valid(s_req0_valid), .Req1Valid(1'b0),
    .Req0Ready(s_req0_ready), .Req1Ready(s_req1_ready),
    .Req0In(16'h1234), .Req1In(16'h0000),
    .Req0Mode(2'b01), .Req1Mode(2'b00),
    .OutValid(s_out_valid), .OutReady(1'b1),
    .OutData(s_out_data), .OutSrc(s_out_src),
    .AcceptCnt(s_cnt), .DbgState(s_state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; Req0Valid = 1'b0; Req1Valid = 1'b0; OutReady = 1'b0;
    Req0In = '0; Req1In = '0; Req0Mode = 2'b00; Req1Mode = 2'b00;
    s_req0_valid = 1'b0;
    #2;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", OutValid); end
    checks++; if (OutData !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", OutData); end
    checks++; if (OutSrc !== 1'b0) begin errors++; $display("FAIL reset_src got %0b want 0", OutSrc); end
    checks++; if (AcceptCnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %0d want 0", AcceptCnt); end
    checks++; if (DbgState !== ST_EMPTY) begin errors++; $display("FAIL reset_state got %0d want 0", DbgState); end
    @(posedge Clk); @(negedge Clk);
    Reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    Req0Valid = 1'b1; Req0In = 16'h8001; Req0Mode = 2'b00; OutReady = 1'b1;
    #1;
    checks++; if (Req0Ready !== 1'b1) begin errors++; $display("FAIL single_ready0 got %0b want 1", Req0Ready); end
    checks++; if (Req1Ready !== 1'b0) begin errors++; $display("FAIL single_ready1 got %0b want 0", Req1Ready); end
    step();
    Req0Valid = 1'b0;
    checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", OutValid); end
    checks++; if (OutData !== 32'hFFFF8001) begin errors++; $display("FAIL single_data got %h want ffff8001", OutData); end
    checks++; if (OutSrc !== 1'b0) begin errors++; $display("FAIL single_src got %0b want 0", OutSrc); end
    checks++; if (AcceptCnt !== 16'd1) begin errors++; $display("FAIL single_cnt got %0d want 1", AcceptCnt); end
    step();
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL single_drain got %0b want 0", OutValid); end
    checks++; if (OutData !== 32'hFFFF8001) begin errors++; $display("FAIL single_hold got %h want ffff8001", OutData); end
  endtask

  task automatic test_modes();
    logic [15:0] ins [4];
    logic [1:0]  modes [4];
    logic [31:0] exps [4];
    ins[0] = 16'hFFFE; modes[0] = 2'b01; exps[0] = 32'h0000FFFE;
    ins[1] = 16'hFFFE; modes[1] = 2'b10; exps[1] = 32'hFFFE0000;
    ins[2] = 16'hFFFE; modes[2] = 2'b11; exps[2] = 32'hFFFFFFF8;
    ins[3] = 16'h0004; modes[3] = 2'b11; exps[3] = 32'h00000010;
    OutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Req1Valid = 1'b1; Req1In = ins[i]; Req1Mode = modes[i];
      step();
      checks++; if (OutData !== exps[i]) begin errors++; $display("FAIL mode_data[%0d] got %h want %h", i, OutData, exps[i]); end
      checks++; if (OutSrc !== 1'b1 || OutValid !== 1'b1) begin errors++; $display("FAIL mode_src[%0d] got src %0b valid %0b want 1 1", i, OutSrc, OutValid); end
    end
    Req1Valid = 1'b0;
    step();
  endtask

  task automatic test_contention();
    Reset_n = 1'b0;
    #2;
    Reset_n = 1'b1;
    Req0Valid = 1'b1; Req0In = 16'h0010; Req0Mode = 2'b01;
    Req1Valid = 1'b1; Req1In = 16'h0020; Req1Mode = 2'b01;
    OutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (OutSrc !== 1'(i % 2)) begin errors++; $display("FAIL contention_src[%0d] got %0b want %0d", i, OutSrc, i % 2); end
      checks++; if (OutData !== ((i % 2) ? 32'h20 : 32'h10)) begin errors++; $display("FAIL contention_data[%0d] got %h", i, OutData); end
    end
    checks++; if (AcceptCnt !== 16'd4) begin errors++; $display("FAIL contention_cnt got %0d want 4", AcceptCnt); end
  endtask

  task automatic test_backpressure();
    OutReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (Req0Ready !== 1'b0 || Req1Ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %0b%0b want 00", i, Req0Ready, Req1Ready); end
      checks++; if (OutData !== 32'h20 || OutValid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d] got %h valid %0b want 00000020 1", i, OutData, OutValid); end
      step();
    end
    OutReady = 1'b1;
    #1;
    checks++; if (Req0Ready !== 1'b1 || Req1Ready !== 1'b0) begin errors++; $display("FAIL bp_release_ready got %0b%0b want 10", Req0Ready, Req1Ready); end
    step();
    OutReady = 1'b0;
    checks++; if (OutValid !== 1'b1 || OutSrc !== 1'b0 || OutData !== 32'h10) begin errors++; $display("FAIL bp_drain_accept got valid %0b src %0b data %h want 1 0 00000010", OutValid, OutSrc, OutData); end
    checks++; if (AcceptCnt !== 16'd5) begin errors++; $display("FAIL bp_cnt got %0d want 5", AcceptCnt); end
  endtask

  task automatic test_reset_mid();
    #1;
    Reset_n = 1'b0;
    #1;
    checks++; if (OutValid !== 1'b0 || OutData !== 32'h0 || AcceptCnt !== 16'h0) begin errors++; $display("FAIL midreset got valid %0b data %h cnt %0d want 0 0 0", OutValid, OutData, AcceptCnt); end
    #1;
    Reset_n = 1'b1;
    OutReady = 1'b1;
    #1;
    checks++; if (Req0Ready !== 1'b1 || Req1Ready !== 1'b0) begin errors++; $display("FAIL midreset_grant got %0b%0b want 10", Req0Ready, Req1Ready); end
    step();
    Req0Valid = 1'b0; Req1Valid = 1'b0;
    checks++; if (OutSrc !== 1'b0 || OutValid !== 1'b1) begin errors++; $display("FAIL midreset_src got src %0b valid %0b want 0 1", OutSrc, OutValid); end
    step();
  endtask

  task automatic test_saturation();
    s_req0_valid = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      if (i == 14) begin
        checks++; if (s_cnt !== 4'hE) begin errors++; $display("FAIL sat_cnt14 got %h want e", s_cnt); end
      end
      if (i == 15 || i == 17) begin
        checks++; if (s_cnt !== 4'hF) begin errors++; $display("FAIL sat_cnt%0d got %h want f", i, s_cnt); end
      end
    end
    s_req0_valid = 1'b0;
    checks++; if (s_out_data !== 32'h00001234 || s_out_valid !== 1'b1) begin errors++; $display("FAIL sat_data got %h valid %0b want 00001234 1", s_out_data, s_out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_modes();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
